// File: rtl/btb_if.sv
// Fetch-side lookup and resolve-side update bundle for the branch target buffer.
// The BTB attaches through the slave modport; the fetch/resolve logic uses master.
interface btb_if;
  logic        flush;
  logic [31:0] pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output flush, pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  flush, pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/btb_assoc.sv
// 2-way set-associative BTB: combinational lookup on pc, 2-bit counters,
// per-set LRU replacement, synchronous flush and active-low synchronous reset.
module btb_assoc #(
  parameter int         SETS     = 64,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input logic  clk,
  input logic  rst_n,
  btb_if.slave bus
);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [SETS-1:0]       valid_q  [2];
  logic [SETS-1:0][1:0]  ctr_q    [2];
  logic [TAG_BITS-1:0]   tag_q    [2][SETS];
  logic [31:0]           target_q [2][SETS];
  logic [SETS-1:0]       lru_q;

  logic [IDX_BITS-1:0] idx;
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0] tag;
  logic [TAG_BITS-1:0] u_tag;
  logic                hit0;
  logic                hit1;
  logic [1:0]          rd_ctr;
  logic [31:0]         rd_target;
  logic                u_hit0;
  logic                u_hit1;
  logic                u_hit;
  logic                victim;
  logic                wr_way;
  logic [1:0]          cur_ctr;
  logic [1:0]          next_ctr;
  logic                unused_low;

  assign idx        = bus.pc[IDX_BITS+1:2];
  assign tag        = bus.pc[31:IDX_BITS+2];
  assign u_idx      = bus.upd_pc[IDX_BITS+1:2];
  assign u_tag      = bus.upd_pc[31:IDX_BITS+2];
  assign unused_low = ^{bus.pc[1:0], bus.upd_pc[1:0]};

  // Way 0 wins if both ways ever match, so lookup stays deterministic.
  always_comb begin
    hit0      = valid_q[0][idx] && (tag_q[0][idx] == tag);
    hit1      = valid_q[1][idx] && (tag_q[1][idx] == tag);
    rd_ctr    = hit0 ? ctr_q[0][idx] : ctr_q[1][idx];
    rd_target = hit0 ? target_q[0][idx] : target_q[1][idx];
  end

  assign bus.pred_hit    = hit0 | hit1;
  assign bus.pred_taken  = (hit0 | hit1) & rd_ctr[1];
  assign bus.pred_target = bus.pred_taken ? rd_target : 32'd0;

  // Hits update their own way; misses fill an invalid way first, then the LRU way.
  always_comb begin
    u_hit0 = valid_q[0][u_idx] && (tag_q[0][u_idx] == u_tag);
    u_hit1 = valid_q[1][u_idx] && (tag_q[1][u_idx] == u_tag);
    u_hit  = u_hit0 | u_hit1;
    if (!valid_q[0][u_idx])
      victim = 1'b0;
    else if (!valid_q[1][u_idx])
      victim = 1'b1;
    else
      victim = lru_q[u_idx];
    wr_way  = u_hit ? !u_hit0 : victim;
    cur_ctr = ctr_q[wr_way][u_idx];
    if (bus.upd_taken)
      next_ctr = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
    else
      next_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      ctr_q[0]   <= '0;
      ctr_q[1]   <= '0;
      lru_q      <= '0;
    end else if (bus.flush) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (bus.upd_valid) begin
      if (u_hit) begin
        ctr_q[wr_way][u_idx] <= next_ctr;
        lru_q[u_idx]         <= ~wr_way;
      end else if (bus.upd_taken) begin
        valid_q[wr_way][u_idx] <= 1'b1;
        ctr_q[wr_way][u_idx]   <= CTR_INIT;
        lru_q[u_idx]           <= ~wr_way;
      end
    end
  end

  // Tags and targets carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush && bus.upd_valid && bus.upd_taken) begin
      target_q[wr_way][u_idx] <= bus.upd_target;
      if (!u_hit)
        tag_q[wr_way][u_idx] <= u_tag;
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed and randomized checks of btb_assoc against a recency-ordered
// reference model keyed by word address.
module tb_btb_assoc;
  localparam int SETS = 64;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  btb_if bus ();

  btb_assoc #(.SETS(SETS), .CTR_INIT(2'b10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: an entry exists per word address; eviction removes the
  // least recently touched entry among the two allowed per set.
  int unsigned ctr_m [int unsigned];
  int unsigned tgt_m [int unsigned];
  int unsigned age_m [int unsigned];
  int unsigned now_age;

  task automatic model_clear();
    ctr_m.delete();
    tgt_m.delete();
    age_m.delete();
  endtask

  task automatic model_update(input logic [31:0] p, input logic t, input logic [31:0] tg);
    int unsigned key;
    int unsigned count;
    int unsigned old_key;
    int unsigned old_age;
    key = p >> 2;
    if (ctr_m.exists(key)) begin
      if (t) begin
        ctr_m[key] = (ctr_m[key] == 3) ? 3 : ctr_m[key] + 1;
        tgt_m[key] = tg;
      end else begin
        ctr_m[key] = (ctr_m[key] == 0) ? 0 : ctr_m[key] - 1;
      end
      age_m[key] = now_age;
      now_age++;
    end else if (t) begin
      count   = 0;
      old_key = 0;
      old_age = 32'hFFFF_FFFF;
      foreach (age_m[k]) begin
        if ((k % SETS) == (key % SETS)) begin
          count++;
          if (age_m[k] < old_age) begin
            old_age = age_m[k];
            old_key = k;
          end
        end
      end
      if (count >= 2) begin
        ctr_m.delete(old_key);
        tgt_m.delete(old_key);
        age_m.delete(old_key);
      end
      ctr_m[key] = 2;
      tgt_m[key] = tg;
      age_m[key] = now_age;
      now_age++;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_lookup(input logic [31:0] p, input string name,
                              input logic e_hit, input logic e_taken, input logic [31:0] e_tgt);
    bus.pc = p;
    #1;
    check_output({name, "_hit"},    {31'd0, bus.pred_hit},   {31'd0, e_hit});
    check_output({name, "_taken"},  {31'd0, bus.pred_taken}, {31'd0, e_taken});
    check_output({name, "_target"}, bus.pred_target,         e_tgt);
  endtask

  task automatic check_model(input logic [31:0] p, input string name);
    int unsigned key;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
    key     = p >> 2;
    e_hit   = 1'b0;
    e_taken = 1'b0;
    e_tgt   = 32'd0;
    if (ctr_m.exists(key)) begin
      e_hit   = 1'b1;
      e_taken = (ctr_m[key] >= 2);
      e_tgt   = e_taken ? tgt_m[key] : 32'd0;
    end
    check_lookup(p, name, e_hit, e_taken, e_tgt);
  endtask

  task automatic drive_update(input logic v, input logic [31:0] p, input logic t, input logic [31:0] tg);
    bus.upd_valid  = v;
    bus.upd_pc     = p;
    bus.upd_taken  = t;
    bus.upd_target = tg;
  endtask

  // One edge: the model sees exactly what the DUT samples, then controls return idle.
  task automatic clock_edge();
    @(posedge clk);
    if (!rst_n)
      model_clear();
    else if (bus.flush)
      model_clear();
    else if (bus.upd_valid)
      model_update(bus.upd_pc, bus.upd_taken, bus.upd_target);
    #1;
    rst_n         = 1'b1;
    bus.flush     = 1'b0;
    bus.upd_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] p, input logic t, input logic [31:0] tg);
    drive_update(1'b1, p, t, tg);
    clock_edge();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clock_edge();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [23:0] tags [3];
    logic [5:0]  idx;
    logic [1:0]  low;
    tags[0] = 24'h000000;
    tags[1] = 24'h000001;
    tags[2] = 24'h800001;
    idx = 6'($urandom_range(0, 3));
    low = 2'($urandom_range(0, 3));
    return {tags[$urandom_range(0, 2)], idx, low};
  endfunction

  initial begin
    logic [31:0] flushed [4];
    logic [31:0] rp;
    int unsigned r;
    tests         = 0;
    fails         = 0;
    now_age       = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.pc        = 32'd0;
    drive_update(1'b0, 32'd0, 1'b0, 32'd0);
    model_clear();

    do_reset();
    do_reset();
    check_lookup(32'h100, "reset", 1'b0, 1'b0, 32'd0);

    apply_stimulus(32'h100, 1'b1, 32'h200);
    check_lookup(32'h100, "alloc", 1'b1, 1'b1, 32'h200);
    apply_stimulus(32'h100, 1'b0, 32'h0);
    check_lookup(32'h100, "ctr01", 1'b1, 1'b0, 32'd0);
    apply_stimulus(32'h100, 1'b0, 32'h0);
    check_lookup(32'h100, "ctr00", 1'b1, 1'b0, 32'd0);
    apply_stimulus(32'h100, 1'b0, 32'h0);
    check_lookup(32'h100, "ctr00_sat", 1'b1, 1'b0, 32'd0);
    apply_stimulus(32'h100, 1'b1, 32'h204);
    check_lookup(32'h100, "ctr01_up", 1'b1, 1'b0, 32'd0);

    do_reset();
    apply_stimulus(32'h100, 1'b1, 32'h1100);
    apply_stimulus(32'h500, 1'b1, 32'h1500);
    check_lookup(32'h100, "way_a", 1'b1, 1'b1, 32'h1100);
    check_lookup(32'h500, "way_b", 1'b1, 1'b1, 32'h1500);
    apply_stimulus(32'h100, 1'b1, 32'h1104);
    apply_stimulus(32'h900, 1'b1, 32'h1900);
    check_lookup(32'h100, "lru_keep", 1'b1, 1'b1, 32'h1104);
    check_lookup(32'h500, "lru_evict", 1'b0, 1'b0, 32'd0);
    check_lookup(32'h900, "lru_new", 1'b1, 1'b1, 32'h1900);
    apply_stimulus(32'h300, 1'b1, 32'h3000);
    apply_stimulus(32'h300, 1'b1, 32'h3000);
    apply_stimulus(32'h300, 1'b1, 32'h3000);
    check_lookup(32'h300, "ctr11_sat", 1'b1, 1'b1, 32'h3000);
    apply_stimulus(32'h300, 1'b0, 32'h0);
    check_lookup(32'h300, "ctr11_down", 1'b1, 1'b1, 32'h3000);

    do_reset();
    drive_update(1'b1, 32'h100, 1'b1, 32'h240);
    check_lookup(32'h100, "same_edge_pre", 1'b0, 1'b0, 32'd0);
    clock_edge();
    check_lookup(32'h100, "same_edge_post", 1'b1, 1'b1, 32'h240);

    apply_stimulus(32'h104, 1'b1, 32'h2104);
    apply_stimulus(32'h208, 1'b1, 32'h2208);
    apply_stimulus(32'h40C, 1'b1, 32'h240C);
    check_lookup(32'h40C, "fill", 1'b1, 1'b1, 32'h240C);
    drive_update(1'b1, 32'h300, 1'b1, 32'h3300);
    bus.flush = 1'b1;
    clock_edge();
    flushed[0] = 32'h100;
    flushed[1] = 32'h104;
    flushed[2] = 32'h40C;
    flushed[3] = 32'h300;
    for (int i = 0; i < 4; i++)
      check_lookup(flushed[i], "flush", 1'b0, 1'b0, 32'd0);

    apply_stimulus(32'h104, 1'b1, 32'h4444);
    check_lookup(32'h104, "refill", 1'b1, 1'b1, 32'h4444);
    drive_update(1'b1, 32'h600, 1'b1, 32'h6600);
    bus.flush = 1'b1;
    rst_n     = 1'b0;
    clock_edge();
    check_lookup(32'h600, "rst_upd", 1'b0, 1'b0, 32'd0);
    check_lookup(32'h104, "rst_clear", 1'b0, 1'b0, 32'd0);

    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      rp = rand_pc();
      drive_update(($urandom_range(0, 4) != 0), rp, ($urandom_range(0, 2) != 0), $urandom);
      if (r < 2)
        rst_n = 1'b0;
      else if (r < 5)
        bus.flush = 1'b1;
      check_model(rand_pc(), "rand_pre");
      clock_edge();
      check_model(rp, "rand_upd");
      check_model(rand_pc(), "rand_any");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised 2-way set-associative branch target buffer for the RV32I fetch stage.
- Lookup is combinational on the fetch PC and produces a predicted-taken flag and a target address.
- Updates arrive from the branch-resolve stage, one per cycle at most.
- Adds over the previous single-way BTB: configurable depth, full tag compare, true 2-bit saturating counters, per-set LRU replacement and a synchronous flush.

Parameters:
- SETS, 64, number of sets; power of 2, range 2..1024.
- IDX_BITS, $clog2(SETS), index width; derived, do not override.
- TAG_BITS, 30-IDX_BITS, tag width; derived.
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous invalidate of all entries.
- pc  in  32  fetch-stage PC to look up.
- pred_hit  out  1  valid entry whose tag matches pc.
- pred_taken  out  1  pred_hit and counter MSB is 1.
- pred_target  out  32  stored target when pred_taken, else 0.
- upd_valid  in  1  a resolved branch/jump is presented this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target; meaningful only when upd_taken=1.

Behaviour:
- Address split: index = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]; pc[1:0] ignored. Same split applies to upd_pc.
- Storage per way per set: valid (1), tag (TAG_BITS), target (32), ctr (2). Per set: lru (1), which names the way to replace next.
- Lookup is purely combinational with no added latency.
  - pred_hit = OR over ways of (valid & tag==pc tag).
  - The matching way drives ctr and target.
  - Lookup reads pre-edge state; an update landing on the same set in the same cycle is not bypassed.
- Update, on the clock edge with upd_valid=1 and no reset or flush:
  - Hit in way w, taken: ctr saturating-increments (11 stays 11); target <= upd_target; lru <= ~w.
  - Hit in way w, not taken: ctr saturating-decrements (00 stays 00); target unchanged; lru <= ~w; entry stays valid.
  - Miss, taken: allocate. The victim is way 0 if invalid, else way 1 if invalid, else way lru. Write valid=1, tag, target, ctr=CTR_INIT; lru <= ~victim.
  - Miss, not taken: no state change.
  - Both ways hitting on the same tag cannot occur, because allocation happens only on a miss. The implementation must still pick way 0 if it ever does.
- Reset (rst_n=0 at the edge) clears every valid, ctr and lru bit to 0. Targets and tags are don't-care.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=0 for any pc.
  - Reset asserted mid-stream discards any concurrent update.
- Flush (flush=1 at the edge) clears every valid and lru bit; ctr bits are don't-care.
  - Flush has priority over a concurrent upd_valid; that update is dropped.
  - Reset has priority over flush.
- Counter semantics: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff ctr[1]=1.
- pred_target is forced to 0 whenever pred_taken=0, including on a hit with ctr[1]=0.
- Aliasing: PCs that differ only above the index bits never share an entry without a tag match, so pred_hit stays 0 for them.

Test Plan:
- Reset, then lookup pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0.
- Update upd_pc=0x100, taken, target 0x200; next cycle pc=0x100 → pred_hit=1, pred_taken=1, pred_target=0x200. Then apply two not-taken updates → ctr goes 10→01→00, giving pred_hit=1, pred_taken=0, pred_target=0. Then one taken update → ctr=01, pred_taken still 0.
- With SETS=64, allocate 0x100 then 0x500 (same set, different tags) → both hit with their own targets. Touch 0x100 with a taken update, then allocate 0x900 → 0x500 is evicted and 0x100 and 0x900 still hit.
- Same edge: upd_valid for 0x100 and pc=0x100 → pred_hit=0 that cycle, 1 the next.
- Fill 4 entries, assert flush together with upd_valid(0x300, taken) → after the edge all lookups, including 0x300, give pred_hit=0.
- Assert rst_n=0 for one cycle with upd_valid=1 → no entry allocated; all lookups miss afterwards.
